// File: rtl/prog_loader.sv
// Boot-time program loader: parses a length-prefixed byte frame, writes big-endian
// words into core memory from BASE_ADDR, and releases the core only on a good XOR checksum.
module prog_loader #(
  parameter int ADDR_W    = 10,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              core_run,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_W) - BASE_ADDR);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic [7:0]        csum_q, csum_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              core_run_q, core_run_d;
  logic              load_err_q, load_err_d;
  logic [ADDR_W:0]   words_q, words_d;

  logic        xfer;
  logic [15:0] n_len;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    csum_d      = csum_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    words_d     = words_q;
    xfer        = in_valid && in_ready_q;
    n_len       = {len_q[15:8], in_byte};

    case (state_q)
      S_LEN_HI: if (xfer) begin
        len_d[15:8] = in_byte;
        csum_d      = csum_q ^ in_byte;
        state_d     = S_LEN_LO;
      end
      S_LEN_LO: if (xfer) begin
        len_d  = n_len;
        csum_d = csum_q ^ in_byte;
        if ({1'b0, n_len} > MAX_WORDS) state_d = S_ERR;
        else if (n_len == 16'd0)       state_d = S_CSUM;
        else                           state_d = S_DATA;
      end
      S_DATA: if (xfer) begin
        csum_d = csum_q ^ in_byte;
        asm_d  = {asm_q[15:0], in_byte};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          // words_q doubles as the word index: both start at zero and step together
          mem_we_d    = 1'b1;
          mem_wdata_d = {asm_q, in_byte};
          mem_addr_d  = ADDR_W'(BASE_ADDR) + words_q[ADDR_W-1:0];
          words_d     = words_q + 1'b1;
          if (32'(words_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
        end
      end
      S_CSUM: if (xfer) begin
        state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
      end
      default: ;
    endcase

    in_ready_d = !(state_d == S_DONE || state_d == S_ERR);
    core_run_d = (state_d == S_DONE);
    load_err_d = (state_d == S_ERR);
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_LEN_HI;
      len_q       <= '0;
      cnt_q       <= '0;
      asm_q       <= '0;
      csum_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ADDR_W'(BASE_ADDR);
      mem_wdata_q <= '0;
      core_run_q  <= 1'b0;
      load_err_q  <= 1'b0;
      words_q     <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      csum_q      <= csum_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      core_run_q  <= core_run_d;
      load_err_q  <= load_err_d;
      words_q     <= words_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign core_run     = core_run_q;
  assign load_err     = load_err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (BASE_ADDR 0 and 0x100) share one stream.
module tb_prog_loader;

  localparam int AW = 10;

  logic clk1 = 1'b0;
  logic rst  = 1'b1;
  logic in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;

  logic          rdy0, we0, run0, err0;
  logic [AW-1:0] addr0;
  logic [31:0]   wd0;
  logic [AW:0]   wl0;
  logic          rdy1, we1, run1, err1;
  logic [AW-1:0] addr1;
  logic [31:0]   wd1;
  logic [AW:0]   wl1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem0 [0:(1<<AW)-1];
  logic [31:0] mem1 [0:(1<<AW)-1];
  int wcnt0 [0:(1<<AW)-1];
  int nwe0 = 0, nwe1 = 0;
  int we_cyc0 [0:7];
  int cyc = 0;

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(0)) dut0 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wd0),
    .core_run(run0), .load_err(err0), .words_loaded(wl0));

  prog_loader #(.ADDR_W(AW), .BASE_ADDR(256)) dut1 (
    .clk1(clk1), .rst(rst), .in_valid(in_valid), .in_byte(in_byte),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wd1),
    .core_run(run1), .load_err(err1), .words_loaded(wl1));

  always #5 clk1 = ~clk1;

  // Behavioural memories standing in for the core's unified memory
  always @(posedge clk1) begin
    cyc = cyc + 1;
    if (we0) begin
      mem0[addr0] = wd0;
      wcnt0[addr0] = wcnt0[addr0] + 1;
      if (nwe0 < 8) we_cyc0[nwe0] = cyc;
      nwe0 = nwe0 + 1;
    end
    if (we1) begin
      mem1[addr1] = wd1;
      nwe1 = nwe1 + 1;
    end
  end

  task automatic clear_model();
    for (int i = 0; i < (1<<AW); i++) begin
      mem0[i] = 32'h0;
      mem1[i] = 32'h0;
      wcnt0[i] = 0;
    end
    nwe0 = 0;
    nwe1 = 0;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk1); #1;
    rst = 1'b0;
    @(posedge clk1); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    @(posedge clk1); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk1); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk1); @(posedge clk1); #1;
    checks++;
    if (rdy0 !== 1'b0 || we0 !== 1'b0 || addr0 !== 10'd0 || wd0 !== 32'h0 ||
        run0 !== 1'b0 || err0 !== 1'b0 || wl0 !== 11'd0) begin
      errors++;
      $display("FAIL reset_vals0: rdy=%b we=%b addr=%h wd=%h run=%b err=%b wl=%0d required 0 0 000 0 0 0 0",
               rdy0, we0, addr0, wd0, run0, err0, wl0);
    end
    checks++;
    if (addr1 !== 10'h100) begin
      errors++;
      $display("FAIL reset_addr1: got %h required 100", addr1);
    end
    rst = 1'b0;
    @(posedge clk1); #1;
    checks++;
    if (rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: got %b required 1", rdy0);
    end
    $display("test_reset done");
  endtask

  task automatic test_two_word();
    logic [7:0] s [0:10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    clear_model();
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(s[i]);
    checks++;
    if (run0 !== 1'b0) begin
      errors++;
      $display("FAIL run_before_csum: got %b required 0", run0);
    end
    send_byte(s[10]);
    checks++;
    if (run0 !== 1'b1 || rdy0 !== 1'b0 || err0 !== 1'b0) begin
      errors++;
      $display("FAIL run_after_csum: run=%b rdy=%b err=%b required 1 0 0", run0, rdy0, err0);
    end
    idle(2);
    checks++;
    if (mem0[0] !== 32'h11223344 || mem0[1] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL two_word_mem: got %h %h required 11223344 aabbccdd", mem0[0], mem0[1]);
    end
    checks++;
    if (nwe0 !== 2 || wl0 !== 11'd2) begin
      errors++;
      $display("FAIL two_word_count: we=%0d wl=%0d required 2 2", nwe0, wl0);
    end
    checks++;
    if (nwe0 >= 2 && we_cyc0[1] - we_cyc0[0] !== 4) begin
      errors++;
      $display("FAIL we_spacing: got %0d required 4", we_cyc0[1] - we_cyc0[0]);
    end
    $display("test_two_word done");
  endtask

  task automatic test_zero_len();
    clear_model();
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    checks++;
    if (run0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL zero_len_mid: run=%b rdy=%b required 0 1", run0, rdy0);
    end
    send_byte(8'h00);
    idle(2);
    checks++;
    if (run0 !== 1'b1 || err0 !== 1'b0 || nwe0 !== 0 || wl0 !== 11'd0) begin
      errors++;
      $display("FAIL zero_len: run=%b err=%b we=%0d wl=%0d required 1 0 0 0", run0, err0, nwe0, wl0);
    end
    $display("test_zero_len done");
  endtask

  task automatic test_bad_csum();
    logic [7:0] s [0:10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h47};
    clear_model();
    do_reset();
    for (int i = 0; i < 11; i++) send_byte(s[i]);
    checks++;
    if (err0 !== 1'b1 || run0 !== 1'b0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum: err=%b run=%b rdy=%b required 1 0 0", err0, run0, rdy0);
    end
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    idle(2);
    checks++;
    if (mem0[0] !== 32'h11223344 || mem0[1] !== 32'hAABBCCDD || nwe0 !== 2 ||
        err0 !== 1'b1 || run0 !== 1'b0 || rdy0 !== 1'b0) begin
      errors++;
      $display("FAIL bad_csum_after: m0=%h m1=%h we=%0d err=%b run=%b rdy=%b required 11223344 aabbccdd 2 1 0 0",
               mem0[0], mem0[1], nwe0, err0, run0, rdy0);
    end
    $display("test_bad_csum done");
  endtask

  task automatic test_oversize();
    clear_model();
    do_reset();
    send_byte(8'h04);
    checks++;
    if (err0 !== 1'b0 || rdy0 !== 1'b1) begin
      errors++;
      $display("FAIL oversize_hi: err=%b rdy=%b required 0 1", err0, rdy0);
    end
    send_byte(8'h01);
    checks++;
    if (err0 !== 1'b1 || rdy0 !== 1'b0 || run0 !== 1'b0) begin
      errors++;
      $display("FAIL oversize_lo: err=%b rdy=%b run=%b required 1 0 0", err0, rdy0, run0);
    end
    for (int i = 0; i < 8; i++) send_byte(8'h55);
    idle(2);
    checks++;
    if (nwe0 !== 0 || wl0 !== 11'd0 || err0 !== 1'b1 || err1 !== 1'b1) begin
      errors++;
      $display("FAIL oversize_after: we=%0d wl=%0d err0=%b err1=%b required 0 0 1 1", nwe0, wl0, err0, err1);
    end
    $display("test_oversize done");
  endtask

  task automatic test_gaps();
    logic [7:0] s [0:10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    clear_model();
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_byte(s[i]);
      if (i < 10) idle(3);
    end
    idle(2);
    checks++;
    if (mem1[10'h100] !== 32'h11223344 || mem1[10'h101] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL gaps_mem: got %h %h required 11223344 aabbccdd", mem1[10'h100], mem1[10'h101]);
    end
    checks++;
    if (nwe1 !== 2 || wl1 !== 11'd2 || run1 !== 1'b1 || err1 !== 1'b0) begin
      errors++;
      $display("FAIL gaps_status: we=%0d wl=%0d run=%b err=%b required 2 2 1 0", nwe1, wl1, run1, err1);
    end
    $display("test_gaps done");
  endtask

  task automatic test_mid_reset();
    logic [7:0] s [0:10] = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    clear_model();
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(s[i]);
    idle(1);
    checks++;
    if (wcnt0[0] !== 1 || wcnt0[1] !== 0) begin
      errors++;
      $display("FAIL mid_partial: w0=%0d w1=%0d required 1 0", wcnt0[0], wcnt0[1]);
    end
    // Reset collides with a valid byte; reset must win
    rst = 1'b1;
    in_valid = 1'b1;
    in_byte = 8'hCC;
    @(posedge clk1); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (wl0 !== 11'd0 || rdy0 !== 1'b0 || we0 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_vals: wl=%0d rdy=%b we=%b required 0 0 0", wl0, rdy0, we0);
    end
    @(posedge clk1); #1;
    for (int i = 0; i < 11; i++) send_byte(s[i]);
    idle(2);
    checks++;
    if (wcnt0[0] !== 2 || wcnt0[1] !== 1 || wl0 !== 11'd2 || run0 !== 1'b1 ||
        mem0[1] !== 32'hAABBCCDD) begin
      errors++;
      $display("FAIL mid_reset_resend: w0=%0d w1=%0d wl=%0d run=%b m1=%h required 2 1 2 1 aabbccdd",
               wcnt0[0], wcnt0[1], wl0, run0, mem0[1]);
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    clear_model();
    test_reset();
    test_two_word();
    test_zero_len();
    test_bad_csum();
    test_oversize();
    test_gaps();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
